// File: rtl/booth_r4_seq_acc_if.sv
// rtl/booth_r4_seq_acc_if.sv - operand/result handshake bundle for the radix-4 Booth accumulator
interface booth_r4_seq_acc_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_result;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/booth_r4_seq_acc.sv
// rtl/booth_r4_seq_acc.sv - iterative radix-4 Booth control/accumulate stage (optional BOOTH_EARLY_TERM_EN)
module booth_r4_seq_acc #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_r4_seq_acc_if.slave   bus,
  output logic [WIDTH-1:0]    o_pp_a,
  output logic                o_pp_neg,
  output logic                o_pp_zero,
  output logic                o_pp_one,
  output logic                o_pp_two,
  input  logic [2*WIDTH-1:0]  i_pp_prod,
  output logic                o_busy
);
  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [WIDTH:0]       w_b_ext;
  logic [CW:0]          w_shamt;
  logic [2:0]           w_trip;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;

  // b[-1] is the implicit zero below the LSB; shift amount is 2*cnt
  assign w_b_ext = {r_b, 1'b0};
  assign w_shamt = {r_cnt, 1'b0};
  assign w_trip  = w_b_ext[w_shamt +: 3];
  assign w_sum   = r_acc + (i_pp_prod << w_shamt);

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0]     w_hi;
  // remaining multiplier bits all equal to the sign means every later triplet encodes zero
  assign w_hi   = WIDTH'($signed(r_b) >>> (w_shamt + 1'b1));
  assign w_last = (r_cnt == CW'(ITER - 1)) || (w_hi == '0) || (&w_hi);
`else
  assign w_last = (r_cnt == CW'(ITER - 1));
`endif

  // Booth recoding of the current triplet; idle state forces the zero selection
  always_comb begin
    o_pp_neg  = 1'b0;
    o_pp_zero = 1'b1;
    o_pp_one  = 1'b0;
    o_pp_two  = 1'b0;
    if (r_state == S_CALC) begin
      case (w_trip)
        3'b001, 3'b010: begin o_pp_zero = 1'b0; o_pp_one = 1'b1; end
        3'b011:         begin o_pp_zero = 1'b0; o_pp_two = 1'b1; end
        3'b100:         begin o_pp_zero = 1'b0; o_pp_two = 1'b1; o_pp_neg = 1'b1; end
        3'b101, 3'b110: begin o_pp_zero = 1'b0; o_pp_one = 1'b1; o_pp_neg = 1'b1; end
        default:        begin o_pp_zero = 1'b1; end
      endcase
    end
  end

  // Control FSM with registered handshake outputs; result register survives past DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_sum;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_pp_a         = r_a;
  assign o_busy         = r_busy;
  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_result;
endmodule

// File: tb/tb_booth_r4_seq_acc.sv
// tb/tb_booth_r4_seq_acc.sv - directed self-checking bench for booth_r4_seq_acc
`timescale 1ns/1ps
module tb_booth_r4_seq_acc;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   pp_a;
  logic           pp_neg, pp_zero, pp_one, pp_two;
  logic [2*W-1:0] pp_prod;
  logic           busy;

  int n_checks;
  int n_fail;
  logic [3:0] pp_seq [0:15];

  booth_r4_seq_acc_if #(.WIDTH(W)) bus ();

  booth_r4_seq_acc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .o_pp_a    (pp_a),
    .o_pp_neg  (pp_neg),
    .o_pp_zero (pp_zero),
    .o_pp_one  (pp_one),
    .o_pp_two  (pp_two),
    .i_pp_prod (pp_prod),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // partial-product generator: sign-extended multiplicand times 0/1/2, optionally negated
  logic [2*W-1:0] gen_ext;
  logic [2*W-1:0] gen_mag;
  always_comb begin
    gen_ext = {{W{pp_a[W-1]}}, pp_a};
    gen_mag = '0;
    if (pp_two)      gen_mag = gen_ext << 1;
    else if (pp_one) gen_mag = gen_ext;
    pp_prod = pp_neg ? (~gen_mag + 1'b1) : gen_mag;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one operand pair, count cycles to out_valid, optionally backpressure the result
  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] exp, input int lat_exp, input int hold);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin tick(); k++; end
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    k = 0;
    do begin
      tick();
      bus.in_valid = 1'b0;
      if (busy && k < 16) pp_seq[k] = {pp_neg, pp_zero, pp_one, pp_two};
      k++;
    end while (!bus.out_valid && k < 40);
    check({tag, " latency"}, 64'(k), 64'(lat_exp));
    check({tag, " result"}, 64'(bus.out_result), 64'(exp));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h0001;
        bus.in_b     = 16'h0001;
        tick();
        check({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, " hold result"}, 64'(bus.out_result), 64'(exp));
        check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    tick();
    check({tag, " back idle"}, 64'({bus.in_ready, bus.out_valid, busy}), 64'b100);
    check({tag, " result kept"}, 64'(bus.out_result), 64'(exp));
  endtask

  int lat_one;
  logic [W-1:0] ra, rb;
  logic [2*W-1:0] rexp;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    #12;
    check("reset outputs", 64'({bus.in_ready, bus.out_valid, busy, pp_neg, pp_zero, pp_one, pp_two}),
          64'b1000100);
    check("reset result", 64'(bus.out_result), 64'd0);
    check("reset pp_a", 64'(pp_a), 64'd0);
    rst_n = 1'b1;
    tick();

    run("3x5", 16'd3, 16'd5, 32'h0000000F, 9, 0);

    run("-7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6, 9, 0);
    check("-7x6 pp cnt0", 64'(pp_seq[0]), 64'b1001);
    check("-7x6 pp cnt1", 64'(pp_seq[1]), 64'b0001);
    check("-7x6 pp cnt2", 64'(pp_seq[2]), 64'b0100);
    check("-7x6 pp cnt7", 64'(pp_seq[7]), 64'b0100);

    run("minxmin", 16'h8000, 16'h8000, 32'h40000000, 9, 0);
    run("maxxmax", 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 9, 0);
    run("backpressure", 16'd12, 16'hFFFD, 32'hFFFFFFDC, 9, 5);
    run("after bp", 16'd10, 16'd10, 32'h00000064, 9, 0);

    // abort in the middle of an operation
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h1234;
    bus.in_b     = 16'h5678;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid calc busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 64'({bus.in_ready, bus.out_valid, busy, pp_neg, pp_zero, pp_one, pp_two}),
          64'b1000100);
    check("async reset result", 64'(bus.out_result), 64'd0);
    check("async reset pp_a", 64'(pp_a), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    run("2x2 after reset", 16'd2, 16'd2, 32'h00000004, 9, 0);

`ifdef BOOTH_EARLY_TERM_EN
    lat_one = 2;
`else
    lat_one = 9;
`endif
    run("9x1", 16'd9, 16'd1, 32'h00000009, lat_one, 0);
    run("9x-1", 16'd9, 16'hFFFF, 32'hFFFFFFF7, lat_one, 0);

    for (int i = 0; i < 8; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rexp = 32'($signed(ra) * $signed(rb));
      run("sweep", ra, rb, rexp, (rb == 16'h0000 || rb == 16'hFFFF) ? lat_one : lat_exp_guess(rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // expected cycle count from presentation to out_valid for a given multiplier
  function automatic int lat_exp_guess(input logic [W-1:0] b);
    int n;
    n = W / 2;
`ifdef BOOTH_EARLY_TERM_EN
    for (int c = 0; c < W / 2; c++) begin
      logic [W-1:0] hi;
      hi = W'($signed(b) >>> (2 * c + 1));
      if (hi == '0 || hi == '1) begin
        n = c + 1;
        break;
      end
    end
`endif
    return n + 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
